bank_pingpong_mem: RTL and testbench
====================================

BANK_PINGPONG_MEM -- requirements
Module: bank_pingpong_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 2**`BANK_ADDR_WIDTH, meaning words per bank.
REQ-002 SHALL have ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
REQ-003 SHALL have port pingpong_in  in  1  0: merge reads set A, writes set B; 1: reads B, writes A.
REQ-004 SHALL have port merge_active_in  in  1  merge engine owns the banks.
REQ-005 SHALL have merge read ports:
- read_addr_in  in  `BANK_ADDR_WIDTH
- read_en_in  in  1
REQ-006 SHALL have merge read-data ports:
- even_data_out  out  tuple_pair_t
- odd_data_out  out  tuple_pair_t
- read_valid_out  out  1
REQ-007 SHALL have merge write ports:
- write_addr_in  in  `BANK_ADDR_WIDTH
- write_en_in  in  1
- even_data_in  in  tuple_pair_t
- odd_data_in  in  tuple_pair_t
REQ-008 SHALL have host request ports:
- host_set_in  in  1  (0=A, 1=B)
- host_addr_in  in  `BANK_ADDR_WIDTH
- host_wr_en_in  in  1
- host_rd_en_in  in  1
REQ-009 SHALL have host write-data ports:
- host_even_in  in  tuple_pair_t
- host_odd_in  in  tuple_pair_t
REQ-010 SHALL have host read-data ports:
- host_even_out  out  tuple_pair_t
- host_odd_out  out  tuple_pair_t
- host_rd_valid_out  out  1
REQ-011 SHALL have status ports:
- host_busy_out  out  1  host request dropped.
- wr_count_a_out  out  `BANK_ADDR_WIDTH+1  writes to set A since the last clear.
- wr_count_b_out  out  `BANK_ADDR_WIDTH+1  writes to set B since the last clear.

Function
REQ-012 SHALL hold four synchronous RAMs, each DEPTH x tuple_pair_t: A_even, A_odd, B_even, B_odd.
REQ-013 Merge read, read_en_in=1 at cycle N: SHALL present the read-set even and odd words at read_addr_in on *_data_out, with read_valid_out=1, in cycle N+1.
REQ-014 Read-set selection SHALL use pingpong_in sampled at cycle N, so a pingpong toggle at N+1 does not affect the in-flight read.
REQ-015 Merge write, write_en_in=1: SHALL write even_data_in and odd_data_in at write_addr_in into the write-set pair on that edge.
REQ-016 Merge read and merge write in the same cycle SHALL both complete, since they target different sets.
REQ-017 Data outputs SHALL hold their last value while the corresponding valid is low.
REQ-018 Host accesses SHALL be honoured only while merge_active_in=0.
REQ-019 A host request while merge_active_in=1 SHALL be dropped, with host_busy_out=1 in the next cycle.
REQ-020 Host write SHALL write both banks of host_set_in at host_addr_in.
REQ-021 Host read SHALL give 1-cycle latency on host_*_out, with host_rd_valid_out=1.
REQ-022 host_wr_en_in and host_rd_en_in together SHALL execute the write only; no host_rd_valid_out.
REQ-023 A read and write to the same set/address in the same cycle SHALL return old data (read-first).
REQ-024 wr_count_x SHALL increment on each write into set x, saturating at DEPTH.
REQ-025 Each pingpong_in edge SHALL clear the count of the new write set in the following cycle.
REQ-026 Memory contents SHALL persist across pingpong_in toggles.

Reset
REQ-027 Reset SHALL drive all outputs to 0: valids, host_busy_out, counters, data outputs.
REQ-028 Reset SHALL NOT initialise RAM contents.
REQ-029 Reset asserted mid-read SHALL suppress the pending valid.

Structure
REQ-030 tuple_pair_t and `BANK_ADDR_WIDTH SHALL come from the shared aoc5 package/defines.
REQ-031 One sub-module, bank_ram (1R1W, read-first, 1-cycle read), SHALL be instantiated four times.

Verification
REQ-032 Host load: write A[0..3] even=10,20,30,40, odd=11,21,31,41; read A[2] -> next cycle host_even_out=30, host_odd_out=31, wr_count_a_out=4.
REQ-033 Pingpong 0: merge read addr 1 while writing B[1]=99 in the same cycle -> read data A[1]=(20,21); B[1] holds 99.
REQ-034 Read issued with pingpong_in=0, pingpong_in toggles the next cycle -> returned data from set A.
REQ-035 host_wr_en_in with merge_active_in=1 -> no RAM change; host_busy_out=1 one cycle later.
REQ-036 Reset asserted the cycle after read_en_in -> read_valid_out stays 0; all counters 0.
REQ-037 DEPTH+3 writes to set B -> wr_count_b_out saturates at DEPTH; pingpong toggle to 1 -> wr_count_a_out cleared.

Source files
------------

// File: rtl/aoc5_pkg.sv
// aoc5 shared types: the key/value tuple pair stored in each bank word.
// Also provides the default bank address width when no project define exists.
`default_nettype none
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

package aoc5_pkg;
  typedef struct packed {
    logic [15:0] key;
    logic [15:0] value;
  } tuple_pair_t;

  localparam int unsigned C_NUM_SETS = 2;
endpackage
`default_nettype wire

// File: rtl/bank_pingpong_mem_ram.sv
// /*------------------------------------------------------------------
//  * bank_ram: 1R1W synchronous RAM, read-first, 1-cycle read latency
//  * rev 1.0
//  *------------------------------------------------------------------*/
`default_nettype none
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

module bank_ram
  import aoc5_pkg::*;
#(
  parameter int DEPTH = 2**`BANK_ADDR_WIDTH,
  parameter int AW    = `BANK_ADDR_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  tuple_pair_t   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output tuple_pair_t   rd_data
);

  tuple_pair_t r_mem [DEPTH];
  tuple_pair_t r_rd_data;

  always_ff @(posedge clock) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clock) begin
    if (reset)      r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/bank_pingpong_mem.sv
// /*------------------------------------------------------------------
//  * bank_pingpong_mem: two ping-pong even/odd bank sets shared by a
//  * merge engine and a host port. rev 1.0
//  *------------------------------------------------------------------*/
`default_nettype none
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

module bank_pingpong_mem
  import aoc5_pkg::*;
#(
  parameter int DEPTH = 2**`BANK_ADDR_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pingpong_in,
  input  logic                        merge_active_in,
  input  logic [`BANK_ADDR_WIDTH-1:0] read_addr_in,
  input  logic                        read_en_in,
  output tuple_pair_t                 even_data_out,
  output tuple_pair_t                 odd_data_out,
  output logic                        read_valid_out,
  input  logic [`BANK_ADDR_WIDTH-1:0] write_addr_in,
  input  logic                        write_en_in,
  input  tuple_pair_t                 even_data_in,
  input  tuple_pair_t                 odd_data_in,
  input  logic                        host_set_in,
  input  logic [`BANK_ADDR_WIDTH-1:0] host_addr_in,
  input  logic                        host_wr_en_in,
  input  logic                        host_rd_en_in,
  input  tuple_pair_t                 host_even_in,
  input  tuple_pair_t                 host_odd_in,
  output tuple_pair_t                 host_even_out,
  output tuple_pair_t                 host_odd_out,
  output logic                        host_rd_valid_out,
  output logic                        host_busy_out,
  output logic [`BANK_ADDR_WIDTH:0]   wr_count_a_out,
  output logic [`BANK_ADDR_WIDTH:0]   wr_count_b_out
);

  localparam int            AW      = `BANK_ADDR_WIDTH;
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  // Merge engine owns the banks while active; host owns them otherwise.
  logic w_merge_rd, w_merge_wr, w_host_rd, w_host_wr, w_pp_edge, w_rd_valid;
  assign w_merge_rd = merge_active_in & read_en_in;
  assign w_merge_wr = merge_active_in & write_en_in;
  assign w_host_wr  = ~merge_active_in & host_wr_en_in;
  assign w_host_rd  = ~merge_active_in & host_rd_en_in & ~host_wr_en_in;

  logic [AW-1:0] w_rd_addr, w_wr_addr;
  tuple_pair_t   w_wr_even, w_wr_odd;
  assign w_rd_addr = merge_active_in ? read_addr_in  : host_addr_in;
  assign w_wr_addr = merge_active_in ? write_addr_in : host_addr_in;
  assign w_wr_even = merge_active_in ? even_data_in  : host_even_in;
  assign w_wr_odd  = merge_active_in ? odd_data_in   : host_odd_in;

  logic        r_pp_prev, r_rd_valid, r_rd_set, r_host_valid, r_host_set, r_busy;
  tuple_pair_t r_even_hold, r_odd_hold, r_host_even_hold, r_host_odd_hold;
  assign w_pp_edge = pingpong_in ^ r_pp_prev;

  logic [C_NUM_SETS-1:0] w_rd_en, w_wr_en;
  tuple_pair_t           w_rd_even [C_NUM_SETS];
  tuple_pair_t           w_rd_odd  [C_NUM_SETS];
  logic [AW:0]           w_count   [C_NUM_SETS];

  // Set index 0 is A, 1 is B. pingpong_in names the merge read set.
  for (genvar s = 0; s < C_NUM_SETS; s++) begin : g_set
    localparam logic SET_ID = 1'(s);
    logic [AW:0] r_count;

    assign w_rd_en[s] = (w_merge_rd && pingpong_in == SET_ID) ||
                        (w_host_rd && host_set_in == SET_ID);
    assign w_wr_en[s] = (w_merge_wr && pingpong_in != SET_ID) ||
                        (w_host_wr && host_set_in == SET_ID);

    bank_ram #(.DEPTH(DEPTH), .AW(AW)) u_even (
      .clock(clock), .reset(reset),
      .wr_en(w_wr_en[s]), .wr_addr(w_wr_addr), .wr_data(w_wr_even),
      .rd_en(w_rd_en[s]), .rd_addr(w_rd_addr), .rd_data(w_rd_even[s])
    );

    bank_ram #(.DEPTH(DEPTH), .AW(AW)) u_odd (
      .clock(clock), .reset(reset),
      .wr_en(w_wr_en[s]), .wr_addr(w_wr_addr), .wr_data(w_wr_odd),
      .rd_en(w_rd_en[s]), .rd_addr(w_rd_addr), .rd_data(w_rd_odd[s])
    );

    // A write landing on the clearing edge counts as the first of the new batch.
    always_ff @(posedge clock) begin
      if (reset)
        r_count <= '0;
      else if (w_pp_edge && pingpong_in != SET_ID)
        r_count <= {{AW{1'b0}}, w_wr_en[s]};
      else if (w_wr_en[s] && r_count < C_DEPTH)
        r_count <= r_count + 1'b1;
    end

    assign w_count[s] = r_count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pp_prev        <= 1'b0;
      r_rd_valid       <= 1'b0;
      r_rd_set         <= 1'b0;
      r_host_valid     <= 1'b0;
      r_host_set       <= 1'b0;
      r_busy           <= 1'b0;
      r_even_hold      <= '0;
      r_odd_hold       <= '0;
      r_host_even_hold <= '0;
      r_host_odd_hold  <= '0;
    end else begin
      r_pp_prev    <= pingpong_in;
      r_rd_valid   <= w_merge_rd;
      r_host_valid <= w_host_rd;
      r_busy       <= merge_active_in & (host_wr_en_in | host_rd_en_in);
      if (w_merge_rd) r_rd_set   <= pingpong_in;
      if (w_host_rd)  r_host_set <= host_set_in;
      if (w_rd_valid) begin
        r_even_hold <= w_rd_even[r_rd_set];
        r_odd_hold  <= w_rd_odd[r_rd_set];
      end
      if (r_host_valid) begin
        r_host_even_hold <= w_rd_even[r_host_set];
        r_host_odd_hold  <= w_rd_odd[r_host_set];
      end
    end
  end

  // Reset masks an in-flight valid immediately rather than one edge later.
  assign w_rd_valid        = r_rd_valid & ~reset;
  assign read_valid_out    = w_rd_valid;
  assign even_data_out     = w_rd_valid ? w_rd_even[r_rd_set] : r_even_hold;
  assign odd_data_out      = w_rd_valid ? w_rd_odd[r_rd_set]  : r_odd_hold;
  assign host_rd_valid_out = r_host_valid;
  assign host_even_out     = r_host_valid ? w_rd_even[r_host_set] : r_host_even_hold;
  assign host_odd_out      = r_host_valid ? w_rd_odd[r_host_set]  : r_host_odd_hold;
  assign host_busy_out     = r_busy;
  assign wr_count_a_out    = w_count[0];
  assign wr_count_b_out    = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_bank_pingpong_mem.sv
// Directed self-checking bench for bank_pingpong_mem.
`default_nettype none
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

module tb_bank_pingpong_mem;
  import aoc5_pkg::*;

  localparam int AW    = `BANK_ADDR_WIDTH;
  localparam int DEPTH = 2**AW;

  logic          clock = 1'b0;
  logic          reset, pingpong_in, merge_active_in;
  logic [AW-1:0] read_addr_in, write_addr_in, host_addr_in;
  logic          read_en_in, write_en_in, host_set_in, host_wr_en_in, host_rd_en_in;
  tuple_pair_t   even_data_in, odd_data_in, host_even_in, host_odd_in;
  tuple_pair_t   even_data_out, odd_data_out, host_even_out, host_odd_out;
  logic          read_valid_out, host_rd_valid_out, host_busy_out;
  logic [AW:0]   wr_count_a_out, wr_count_b_out;

  int n_cmp = 0;
  int n_err = 0;

  bank_pingpong_mem #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .pingpong_in(pingpong_in),
    .merge_active_in(merge_active_in),
    .read_addr_in(read_addr_in), .read_en_in(read_en_in),
    .even_data_out(even_data_out), .odd_data_out(odd_data_out),
    .read_valid_out(read_valid_out),
    .write_addr_in(write_addr_in), .write_en_in(write_en_in),
    .even_data_in(even_data_in), .odd_data_in(odd_data_in),
    .host_set_in(host_set_in), .host_addr_in(host_addr_in),
    .host_wr_en_in(host_wr_en_in), .host_rd_en_in(host_rd_en_in),
    .host_even_in(host_even_in), .host_odd_in(host_odd_in),
    .host_even_out(host_even_out), .host_odd_out(host_odd_out),
    .host_rd_valid_out(host_rd_valid_out), .host_busy_out(host_busy_out),
    .wr_count_a_out(wr_count_a_out), .wr_count_b_out(wr_count_b_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pingpong_in = 1'b0; merge_active_in = 1'b0;
    read_addr_in = '0; write_addr_in = '0; host_addr_in = '0;
    read_en_in = 1'b0; write_en_in = 1'b0; host_set_in = 1'b0;
    host_wr_en_in = 1'b0; host_rd_en_in = 1'b0;
    even_data_in = '0; odd_data_in = '0; host_even_in = '0; host_odd_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_read_valid", 32'(read_valid_out), 0);
    check("rst_host_valid", 32'(host_rd_valid_out), 0);
    check("rst_busy", 32'(host_busy_out), 0);
    check("rst_count_a", 32'(wr_count_a_out), 0);
    check("rst_count_b", 32'(wr_count_b_out), 0);
    check("rst_even_out", even_data_out, 0);
    check("rst_host_even", host_even_out, 0);

    // Host load of set A
    host_set_in = 1'b0;
    host_wr_en_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_addr_in = AW'(i);
      host_even_in = tuple_pair_t'(32'(10 * (i + 1)));
      host_odd_in  = tuple_pair_t'(32'(10 * (i + 1) + 1));
      tick();
    end
    host_wr_en_in = 1'b0;
    host_rd_en_in = 1'b1; host_addr_in = AW'(2);
    tick();
    host_rd_en_in = 1'b0;
    check("host_rd_valid", 32'(host_rd_valid_out), 1);
    check("host_even_a2", host_even_out, 30);
    check("host_odd_a2", host_odd_out, 31);
    check("count_a_load", 32'(wr_count_a_out), 4);
    check("count_b_load", 32'(wr_count_b_out), 0);
    tick();
    check("host_valid_drop", 32'(host_rd_valid_out), 0);
    check("host_even_hold", host_even_out, 30);

    // Merge read A[1] and write B[1] in the same cycle
    merge_active_in = 1'b1;
    read_en_in = 1'b1; read_addr_in = AW'(1);
    write_en_in = 1'b1; write_addr_in = AW'(1);
    even_data_in = tuple_pair_t'(32'd99); odd_data_in = tuple_pair_t'(32'd100);
    tick();
    read_en_in = 1'b0; write_en_in = 1'b0;
    check("merge_valid", 32'(read_valid_out), 1);
    check("merge_even_a1", even_data_out, 20);
    check("merge_odd_a1", odd_data_out, 21);
    check("count_b_merge", 32'(wr_count_b_out), 1);
    merge_active_in = 1'b0;
    host_set_in = 1'b1; host_rd_en_in = 1'b1; host_addr_in = AW'(1);
    tick();
    host_rd_en_in = 1'b0;
    check("host_even_b1", host_even_out, 99);
    check("host_odd_b1", host_odd_out, 100);
    check("merge_valid_low", 32'(read_valid_out), 0);
    check("merge_even_hold", even_data_out, 20);

    // Read issued at pingpong 0, toggle the following cycle
    merge_active_in = 1'b1;
    read_en_in = 1'b1; read_addr_in = AW'(3);
    tick();
    read_en_in = 1'b0; pingpong_in = 1'b1;
    check("inflight_valid", 32'(read_valid_out), 1);
    check("inflight_even_a3", even_data_out, 40);
    check("inflight_odd_a3", odd_data_out, 41);
    tick();
    check("toggle_clear_a", 32'(wr_count_a_out), 0);
    check("toggle_keep_b", 32'(wr_count_b_out), 1);

    // Contents persist across toggles
    read_en_in = 1'b1; read_addr_in = AW'(1);
    tick();
    check("pp1_even_b1", even_data_out, 99);
    pingpong_in = 1'b0; read_addr_in = AW'(0);
    tick();
    read_en_in = 1'b0;
    check("pp0_even_a0", even_data_out, 10);
    check("toggle_clear_b", 32'(wr_count_b_out), 0);

    // Host write dropped while merge owns the banks
    host_set_in = 1'b0; host_addr_in = AW'(0); host_wr_en_in = 1'b1;
    host_even_in = tuple_pair_t'(32'd555);
    tick();
    host_wr_en_in = 1'b0;
    check("busy_set", 32'(host_busy_out), 1);
    check("busy_count_a", 32'(wr_count_a_out), 0);
    merge_active_in = 1'b0; host_rd_en_in = 1'b1;
    tick();
    host_rd_en_in = 1'b0;
    check("busy_no_write", host_even_out, 10);
    check("busy_clear", 32'(host_busy_out), 0);

    // Saturation of the set B counter, then toggle clears A only
    host_wr_en_in = 1'b1; host_addr_in = AW'(5);
    tick(); tick();
    host_wr_en_in = 1'b0;
    merge_active_in = 1'b1; write_en_in = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      write_addr_in = AW'(i);
      even_data_in  = tuple_pair_t'(32'(i));
      tick();
    end
    write_en_in = 1'b0;
    check("sat_count_b", 32'(wr_count_b_out), DEPTH);
    check("sat_count_a", 32'(wr_count_a_out), 2);
    pingpong_in = 1'b1;
    tick();
    check("sat_toggle_a", 32'(wr_count_a_out), 0);
    check("sat_toggle_b", 32'(wr_count_b_out), DEPTH);

    // Reset asserted the cycle after a read issue
    read_en_in = 1'b1; read_addr_in = AW'(2);
    tick();
    read_en_in = 1'b0; reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(read_valid_out), 0);
    tick();
    check("rst_after_valid", 32'(read_valid_out), 0);
    check("rst_after_count_a", 32'(wr_count_a_out), 0);
    check("rst_after_count_b", 32'(wr_count_b_out), 0);
    check("rst_after_even", even_data_out, 0);
    reset = 1'b0;
    tick();
    check("post_rst_valid", 32'(read_valid_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
